// File: rtl/brick_sort_ctrl.sv
// rtl/brick_sort_ctrl.sv - control and storage stage of the brick (odd-even transposition) sorter
//
// Captures one vector of N = 2**LOG_INPUT_NUM elements, then runs N phases.
// In each phase the registered vector q and phase counter feed an external
// compare-exchange stage, and that stage's result din is written back into q.
// After the last phase the sorted vector is presented on out_data.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data, in_valid   unsorted vector, offered to the block
//   in_ready            block is idle and will take in_data
//   q, counter          working vector and phase number (bit 0: 0 = even pairs, 1 = odd pairs)
//   din                 compare-exchange result for the current q/counter
//   out_data, out_valid sorted vector (same as q) and its valid flag
//   out_ready           consumer takes the result
//   busy                sorting phases in progress
module brick_sort_ctrl #(
  parameter int LOG_INPUT_NUM = 4,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [(DATA_WIDTH<<LOG_INPUT_NUM)-1:0] in_data,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [(DATA_WIDTH<<LOG_INPUT_NUM)-1:0] q,
  output logic [31:0]                            counter,
  input  logic [(DATA_WIDTH<<LOG_INPUT_NUM)-1:0] din,
  output logic [(DATA_WIDTH<<LOG_INPUT_NUM)-1:0] out_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   busy
);

  localparam int          N          = 1 << LOG_INPUT_NUM;
  localparam logic [31:0] LAST_PHASE = 32'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Handshake outputs decode the state register only, so no input reaches
  // an output combinationally.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = SORT;
        end
      end
      SORT: begin
        busy = 1'b1;
        if (counter == LAST_PHASE) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // q and counter are not cleared on leaving DONE; they hold the last
  // result until the next vector is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= '0;
      counter <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            q       <= in_data;
            counter <= '0;
          end
        end
        SORT: begin
          q       <= din;
          counter <= counter + 32'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign out_data = q;

endmodule

// File: tb/tb_brick_sort_ctrl.sv
// tb/tb_brick_sort_ctrl.sv - scoreboard bench for brick_sort_ctrl with an ascending 4x8 compare-exchange stage
module tb_brick_sort_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] q;
  logic [31:0] counter;
  logic [31:0] din;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_pop = 0;
  logic [31:0] sb[$];
  int          acc_cyc[$];

  brick_sort_ctrl #(
    .LOG_INPUT_NUM(2),
    .DATA_WIDTH   (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .q        (q),
    .counter  (counter),
    .din      (din),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Ascending unsigned compare-exchange stage: even phase (0,1),(2,3); odd phase (1,2).
  always_comb begin
    din = q;
    for (int i = 0; i < 3; i++) begin
      if ((i % 2) == int'(counter[0])) begin
        if (q[8*i +: 8] > q[8*(i+1) +: 8]) begin
          din[8*i +: 8]     = q[8*(i+1) +: 8];
          din[8*(i+1) +: 8] = q[8*i +: 8];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    logic [7:0] ea, eb, ec, ed;
    ea = a[7:0]; eb = b[7:0]; ec = c[7:0]; ed = d[7:0];
    return {ed, ec, eb, ea};
  endfunction

  function automatic logic [31:0] srt(input logic [31:0] v);
    logic [7:0] e[4];
    logic [7:0] t;
    for (int i = 0; i < 4; i++) e[i] = v[8*i +: 8];
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 3; i++)
        if (e[i] > e[i+1]) begin
          t = e[i]; e[i] = e[i+1]; e[i+1] = t;
        end
    return {e[3], e[2], e[1], e[0]};
  endfunction

  // Inputs change only at posedge+1, so values seen here are what the next edge samples.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        sb.push_back(srt(in_data));
        acc_cyc.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_extra_out", 1, 0);
        end else begin
          check("out_data", out_data, sb.pop_front());
          check("out_counter", counter, 4);
        end
        n_pop++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] seq[4];
  logic [31:0] hold;
  int          base;
  int          base_pop;
  int          cnt;
  bit          ok;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    check("rst_q", q, 0);
    check("rst_counter", counter, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    // Reverse input with backpressure in DONE
    seq[0] = pk(4, 3, 2, 1);
    seq[1] = pk(3, 4, 1, 2);
    seq[2] = pk(3, 1, 4, 2);
    seq[3] = pk(1, 3, 2, 4);
    @(posedge clk); #1 in_valid = 1'b1; in_data = pk(4, 3, 2, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rev_counter", counter, k);
      check("rev_q", q, seq[k]);
      check("rev_busy", busy, 1);
      check("rev_out_valid_early", out_valid, 0);
    end
    @(negedge clk);
    check("rev_out_valid", out_valid, 1);
    check("rev_result", out_data, pk(1, 2, 3, 4));
    check("rev_done_counter", counter, 4);
    check("rev_done_busy", busy, 0);
    hold = out_data;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_stable", out_data, hold);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_accept_in_ready", in_ready, 0);
    @(negedge clk);
    check("bp_idle_out_valid", out_valid, 0);
    check("bp_idle_in_ready", in_ready, 1);
    check("bp_hold_q", q, pk(1, 2, 3, 4));
    check("bp_hold_counter", counter, 4);
    check("bp_popped", n_pop, 1);

    // Back-to-back vectors with in_valid held high
    base = acc_cyc.size();
    base_pop = n_pop;
    @(posedge clk); #1 in_valid = 1'b1; in_data = pk(9, 9, 0, 5);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = (acc_cyc.size() > base);
    end
    check("b2b_first_accept", ok, 1);
    @(posedge clk); #1 in_data = pk(7, 1, 7, 1);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = (acc_cyc.size() > base + 1);
    end
    check("b2b_second_accept", ok, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = (n_pop - base_pop == 2);
    end
    check("b2b_two_results", n_pop - base_pop, 2);
    if (acc_cyc.size() >= base + 2)
      check("b2b_accept_gap", acc_cyc[base+1] - acc_cyc[base], 6);

    // Reset in phase 2
    @(posedge clk); #1 in_valid = 1'b1; in_data = pk(4, 3, 2, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = (counter == 2) && busy;
    end
    check("rmid_reached_phase2", ok, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rmid_q", q, 0);
    check("rmid_counter", counter, 0);
    check("rmid_busy", busy, 0);
    check("rmid_in_ready", in_ready, 1);
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("rmid_no_out_valid", cnt, 0);

    // Duplicates
    base_pop = n_pop;
    @(posedge clk); #1 in_valid = 1'b1; in_data = pk(5, 5, 5, 5);
    @(posedge clk); #1 in_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    check("dup_busy_cycles", cnt, 4);
    check("dup_result_seen", n_pop - base_pop, 1);
    check("dup_q", q, pk(5, 5, 5, 5));

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
